// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared types and default widths for the SDRAM voice arbiter
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 13;
  localparam int SDRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    REFRESH,
    ISSUE,
    WAIT_DATA
  } sdram_arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker: first request at or after ptr, wrapping
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    any  = |req;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (req[cand]) begin
        idx = cand;
        gnt = {{(N-1){1'b0}}, 1'b1} << cand;
      end
    end
  end

endmodule

// File: rtl/sdram_voice_arbiter.sv
// rtl/sdram_voice_arbiter.sv - round-robin SDRAM read arbiter for drum voices with refresh priority
// Optional read-data watchdog is enabled by defining SDRAM_ARB_WATCHDOG_EN.
module sdram_voice_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_VOICES       = 4,
  parameter int ADDR_W           = SDRAM_ADDR_W,
  parameter int DATA_W           = SDRAM_DATA_W,
  parameter int REFRESH_INTERVAL = 390,
  parameter int TIMEOUT          = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_VOICES-1:0]        voice_req,
  input  logic [NUM_VOICES*ADDR_W-1:0] voice_addr,
  output logic [NUM_VOICES-1:0]        voice_gnt,
  output logic [NUM_VOICES-1:0]        voice_valid,
  output logic [DATA_W-1:0]            voice_data,
  output logic                         mem_req,
  output logic                         mem_refresh,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_ack,
  input  logic                         mem_rd_valid,
  input  logic [DATA_W-1:0]            mem_rd_data,
  output logic                         refresh_miss,
  output logic                         timeout_err
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int RC_W  = $clog2(REFRESH_INTERVAL);
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFRESH_INTERVAL - 1);

  if (NUM_VOICES < 2 || NUM_VOICES > 8 || REFRESH_INTERVAL < 16 || TIMEOUT < 1) begin : g_param_check
    $error("sdram_voice_arbiter: parameter out of range");
  end

  sdram_arb_state_t        state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        owner;
  logic                    refresh_pending;
  logic [RC_W-1:0]         refresh_cnt;
  logic                    refresh_expire;
  logic                    refresh_clear;
  logic                    pick_any;
  logic [NUM_VOICES-1:0]   pick_gnt;
  logic [IDX_W-1:0]        pick_idx;
  logic [NUM_VOICES-1:0]   owner_onehot;

  assign refresh_expire = (refresh_cnt == '0);
  assign refresh_clear  = (state == REFRESH) && mem_ack;
  assign owner_onehot   = {{(NUM_VOICES-1){1'b0}}, 1'b1} << owner;

`ifdef SDRAM_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  rr_picker #(
    .N     (NUM_VOICES),
    .IDX_W (IDX_W)
  ) u_picker (
    .req (voice_req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // A refresh that is acked on the same cycle the interval expires is immediately re-requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt     <= RC_LOAD;
      refresh_pending <= 1'b0;
      refresh_miss    <= 1'b0;
    end else if (refresh_expire) begin
      refresh_cnt     <= RC_LOAD;
      refresh_pending <= 1'b1;
      if (refresh_pending && !refresh_clear) begin
        refresh_miss <= 1'b1;
      end
    end else begin
      refresh_cnt <= refresh_cnt - RC_W'(1);
      if (refresh_clear) begin
        refresh_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      voice_gnt   <= '0;
      voice_valid <= '0;
      voice_data  <= '0;
      mem_req     <= 1'b0;
      mem_refresh <= 1'b0;
      mem_addr    <= '0;
`ifdef SDRAM_ARB_WATCHDOG_EN
      wd_cnt      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      voice_gnt   <= '0;
      voice_valid <= '0;
      unique case (state)
        IDLE: begin
          if (refresh_pending) begin
            state       <= REFRESH;
            mem_refresh <= 1'b1;
          end else if (pick_any) begin
            state     <= ISSUE;
            mem_req   <= 1'b1;
            voice_gnt <= pick_gnt;
            mem_addr  <= voice_addr[pick_idx*ADDR_W +: ADDR_W];
            owner     <= pick_idx;
            rr_ptr    <= (pick_idx == IDX_W'(NUM_VOICES - 1)) ? '0 : pick_idx + IDX_W'(1);
          end
        end
        REFRESH: begin
          if (mem_ack) begin
            state       <= IDLE;
            mem_refresh <= 1'b0;
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            state   <= WAIT_DATA;
            mem_req <= 1'b0;
`ifdef SDRAM_ARB_WATCHDOG_EN
            wd_cnt  <= '0;
`endif
          end
        end
        WAIT_DATA: begin
          if (mem_rd_valid) begin
            state       <= IDLE;
            voice_data  <= mem_rd_data;
            voice_valid <= owner_onehot;
          end
`ifdef SDRAM_ARB_WATCHDOG_EN
          // Release the voice with a zero sample so one lost read cannot stall every voice.
          else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            state       <= IDLE;
            timeout_q   <= 1'b1;
            voice_data  <= '0;
            voice_valid <= owner_onehot;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_voice_arbiter.sv
// tb/tb_sdram_voice_arbiter.sv - scoreboard bench for sdram_voice_arbiter (watchdog case when SDRAM_ARB_WATCHDOG_EN)
module tb_sdram_voice_arbiter;

  localparam int NV = 4;
  localparam int AW = 13;
  localparam int DW = 16;
  localparam int RI = 40;
  localparam int TO = 64;

  localparam int K_GNT = 0;
  localparam int K_VAL = 1;
  localparam int K_REF = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NV-1:0]     voice_req;
  logic [NV*AW-1:0]  voice_addr;
  logic [NV-1:0]     voice_gnt;
  logic [NV-1:0]     voice_valid;
  logic [DW-1:0]     voice_data;
  logic              mem_req;
  logic              mem_refresh;
  logic [AW-1:0]     mem_addr;
  logic              mem_ack;
  logic              mem_rd_valid;
  logic [DW-1:0]     mem_rd_data;
  logic              refresh_miss;
  logic              timeout_err;

  sdram_voice_arbiter #(
    .NUM_VOICES       (NV),
    .ADDR_W           (AW),
    .DATA_W           (DW),
    .REFRESH_INTERVAL (RI),
    .TIMEOUT          (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .voice_req    (voice_req),
    .voice_addr   (voice_addr),
    .voice_gnt    (voice_gnt),
    .voice_valid  (voice_valid),
    .voice_data   (voice_data),
    .mem_req      (mem_req),
    .mem_refresh  (mem_refresh),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .refresh_miss (refresh_miss),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          voice;
    logic [15:0] val;
    bit          aux;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   req_left[NV];
  bit   rd_ack_en = 1'b1;
  bit   ref_ack_en = 1'b1;
  bit   data_en = 1'b1;
  bit   inject_late = 1'b0;
  bit   track_refresh = 1'b0;
  bit   both_seen = 1'b0;
  bit   prev_rd = 1'b0;
  bit   pend_data = 1'b0;
  logic [DW-1:0] pend_val = '0;
  int   last_gnt_cyc = 0;
  int   last_val_cyc = 0;

  function automatic logic [DW-1:0] model(input logic [AW-1:0] a);
    case (a)
      13'h0ABC: return 16'h1234;
      13'h0010: return 16'hA000;
      13'h0011: return 16'hA001;
      13'h0012: return 16'hA002;
      13'h1FFF: return 16'hBEEF;
      default:  return 16'hDEAD;
    endcase
  endfunction

  task automatic push_gnt(input int v, input logic [15:0] a);
    exp_q.push_back('{K_GNT, v, a, 1'b1});
  endtask

  task automatic push_val(input int v, input logic [15:0] d, input bit from_rd);
    exp_q.push_back('{K_VAL, v, d, from_rd});
  endtask

  task automatic push_ref();
    exp_q.push_back('{K_REF, 0, 16'h0000, 1'b1});
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic check_event(input int kind, input logic [NV-1:0] oh, input logic [15:0] val, input bit aux);
    exp_t e;
    logic [NV-1:0] want_oh;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event_kind%0d: unexpected event oh=%b val=%h, none required", kind, oh, val);
      return;
    end
    e = exp_q.pop_front();
    want_oh = (e.kind == K_REF) ? '0 : (NV'(1) << e.voice);
    if (e.kind != kind || oh !== want_oh || val !== e.val || aux !== e.aux) begin
      errors++;
      $display("FAIL event_kind%0d: got kind=%0d oh=%b val=%h aux=%0b, required kind=%0d oh=%b val=%h aux=%0b",
               e.kind, kind, oh, val, aux, e.kind, want_oh, e.val, e.aux);
    end
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d events outstanding after %0d cycles, required 0", name, exp_q.size(), max_cycles);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < NV; i++) req_left[i] = 0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_addr(input int v, input logic [AW-1:0] a);
    voice_addr[v*AW +: AW] = a;
  endtask

  always @(posedge clk) cyc++;

  initial begin
    voice_req = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NV; i++) begin
        if (voice_gnt[i] && req_left[i] > 0) req_left[i]--;
        voice_req[i] = (req_left[i] > 0);
      end
    end
  end

  initial begin
    mem_ack = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      mem_rd_valid = 1'b0;
      if (reset) begin
        pend_data = 1'b0;
      end else begin
        if (inject_late) begin
          mem_rd_valid = 1'b1;
          mem_rd_data = 16'h7777;
          inject_late = 1'b0;
        end
        if (pend_data) begin
          mem_rd_valid = 1'b1;
          mem_rd_data = pend_val;
          pend_data = 1'b0;
        end
        if (mem_refresh && ref_ack_en) begin
          mem_ack = 1'b1;
        end else if (mem_req && rd_ack_en) begin
          mem_ack = 1'b1;
          if (data_en) begin
            pend_data = 1'b1;
            pend_val = model(mem_addr);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req && mem_refresh) both_seen = 1'b1;
      if (track_refresh && mem_refresh && mem_ack) check_event(K_REF, '0, 16'h0000, !mem_req);
      if (voice_gnt != '0) begin
        last_gnt_cyc = cyc;
        check_event(K_GNT, voice_gnt, DW'(mem_addr), mem_req);
      end
      if (voice_valid != '0) begin
        last_val_cyc = cyc;
        check_event(K_VAL, voice_valid, voice_data, prev_rd);
      end
      prev_rd = mem_rd_valid;
    end else begin
      prev_rd = 1'b0;
    end
  end

  initial begin
    reset = 1'b1;
    voice_addr = '0;
    for (int i = 0; i < NV; i++) req_left[i] = 0;
    set_addr(0, 13'h0010);
    set_addr(1, 13'h0011);
    set_addr(2, 13'h0ABC);
    set_addr(3, 13'h1FFF);
    do_reset();

    chk("rst_voice_gnt", voice_gnt, 0);
    chk("rst_voice_valid", voice_valid, 0);
    chk("rst_voice_data", voice_data, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_refresh", mem_refresh, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_refresh_miss", refresh_miss, 0);
    chk("rst_timeout_err", timeout_err, 0);

    // Single request from voice 2.
    push_gnt(2, 16'h0ABC);
    push_val(2, 16'h1234, 1'b1);
    req_left[2] = 1;
    wait_drain(100, "single");

    // Round-robin with all voices requesting; voice 0 asks twice.
    do_reset();
    set_addr(2, 13'h0012);
    push_gnt(0, 16'h0010); push_val(0, 16'hA000, 1'b1);
    push_gnt(1, 16'h0011); push_val(1, 16'hA001, 1'b1);
    push_gnt(2, 16'h0012); push_val(2, 16'hA002, 1'b1);
    push_gnt(3, 16'h1FFF); push_val(3, 16'hBEEF, 1'b1);
    push_gnt(0, 16'h0010); push_val(0, 16'hA000, 1'b1);
    req_left[0] = 2; req_left[1] = 1; req_left[2] = 1; req_left[3] = 1;
    wait_drain(300, "round_robin");

    // Refresh becomes pending while voice 0 is stalled in ISSUE and voice 1 waits.
    do_reset();
    rd_ack_en = 1'b0;
    push_gnt(0, 16'h0010);
    req_left[0] = 1; req_left[1] = 1;
    repeat (45) @(posedge clk);
    #1;
    chk("prio_stalled_mem_req", mem_req, 1);
    push_val(0, 16'hA000, 1'b1);
    push_ref();
    push_gnt(1, 16'h0011);
    push_val(1, 16'hA001, 1'b1);
    track_refresh = 1'b1;
    rd_ack_en = 1'b1;
    wait_drain(100, "refresh_prio");
    track_refresh = 1'b0;
    chk("prio_no_miss", refresh_miss, 0);

    // Refresh starvation.
    do_reset();
    ref_ack_en = 1'b0;
    repeat (RI) @(posedge clk);
    #1;
    chk("first_refresh_not_yet", mem_refresh, 0);
    @(posedge clk);
    #1;
    chk("first_refresh_issued", mem_refresh, 1);
    repeat (37) @(posedge clk);
    #1;
    chk("starve_miss_before_expiry", refresh_miss, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("starve_miss_set", refresh_miss, 1);
    chk("starve_no_read", mem_req, 0);
    ref_ack_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("starve_miss_sticky", refresh_miss, 1);
    do_reset();
    chk("starve_miss_cleared", refresh_miss, 0);

    // Reset while a read is outstanding, then a late mem_rd_valid.
    data_en = 1'b0;
    push_gnt(0, 16'h0010);
    req_left[0] = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("midread_in_wait", mem_req, 0);
    do_reset();
    inject_late = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midread_voice_gnt", voice_gnt, 0);
    chk("midread_voice_valid", voice_valid, 0);
    chk("midread_voice_data", voice_data, 0);
    chk("midread_mem_req", mem_req, 0);
    chk("midread_mem_refresh", mem_refresh, 0);
    chk("midread_mem_addr", mem_addr, 0);
    data_en = 1'b1;
    push_gnt(0, 16'h0010); push_val(0, 16'hA000, 1'b1);
    push_gnt(3, 16'h1FFF); push_val(3, 16'hBEEF, 1'b1);
    req_left[0] = 1; req_left[3] = 1;
    wait_drain(100, "midread_rr_ptr");

`ifdef SDRAM_ARB_WATCHDOG_EN
    do_reset();
    data_en = 1'b0;
    push_gnt(3, 16'h1FFF);
    push_val(3, 16'h0000, 1'b0);
    req_left[3] = 1;
    wait_drain(200, "watchdog");
    chk("wd_timeout_err", timeout_err, 1);
    chk("wd_latency", last_val_cyc - last_gnt_cyc, TO + 1);
    data_en = 1'b1;
    push_gnt(1, 16'h0011); push_val(1, 16'hA001, 1'b1);
    req_left[1] = 1;
    wait_drain(100, "wd_recover");
    chk("wd_timeout_sticky", timeout_err, 1);
`endif

    chk("req_refresh_exclusive", both_seen, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
